mcu_port_fifo: RTL and testbench
================================

Name: mcu_port_fifo

Overview:
- Buffering controller between the MCU port channel of the system-control block and the core's RS232 UART.
- Holds two byte FIFOs:
  - RX FIFO: UART → MCU.
  - TX FIFO: MCU → UART.
- Supplies the available-count, strobe and data signals the system-control block expects, plus the 32-bit port status word.
- Gates and flushes both directions according to the OSD UART selection.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (legal 1..8; depth = 2**DEPTH_LOG2 entries)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
uart_mode  in  2  OSD UART selection; 0 = port disabled, nonzero = enabled
bitrate  in  24  current UART bitrate in baud
line_cfg  in  8  databits/parity/stopbits byte from UART config
port_status  out  32  status word for the MCU
port_out_available  out  8  RX FIFO fill level, saturated at 255
port_out_strobe  in  1  pop one RX byte
port_out_data  out  8  RX FIFO head byte
port_in_available  out  8  TX FIFO free entries, saturated at 255
port_in_strobe  in  1  push port_in_data into TX FIFO
port_in_data  in  8  byte from MCU
rx_valid  in  1  one-cycle pulse: UART received a byte
rx_data  in  8  received byte
tx_valid  out  1  TX FIFO non-empty, byte offered to UART
tx_data  out  8  TX FIFO head byte
tx_ready  in  1  UART transmitter accepts byte this cycle
rx_overflow  out  1  sticky: RX byte dropped because RX FIFO full
tx_overflow  out  1  sticky: MCU push dropped because TX FIFO full

Behaviour:
- Reset values:
  - Both FIFOs empty (pointers and counts 0).
  - port_out_available = 0; port_in_available = min(DEPTH, 255).
  - tx_valid = 0; port_out_data = 0x00; tx_data = 0x00.
  - rx_overflow = 0; tx_overflow = 0.
- Each FIFO has registered rd_ptr/wr_ptr (DEPTH_LOG2 bits, natural wrap) and a count of DEPTH_LOG2+1 bits.
  - Full: count == DEPTH. Empty: count == 0.
- Available outputs are registered from count:
  - port_out_available = min(rx_count, 255).
  - port_in_available = min(DEPTH − tx_count, 255).
  - Both reflect a push/pop on the cycle after the event.
- First-word fall-through:
  - port_out_data = mem_rx[rd_ptr] when rx_count ≠ 0, else 0x00.
  - tx_data = mem_tx[rd_ptr] when tx_count ≠ 0, else 0x00.
  - Both update the cycle after a pop.
- RX push: rx_valid && enabled && !full → write rx_data, wr_ptr+1.
  - If full: byte dropped, rx_overflow ← 1.
- RX pop: port_out_strobe && !empty → rd_ptr+1.
  - Strobe when empty is ignored (no underflow, pointers unchanged).
- TX push: port_in_strobe && enabled && !full → write port_in_data.
  - If full: dropped, tx_overflow ← 1.
- TX pop: tx_valid && tx_ready → rd_ptr+1. tx_valid = (tx_count ≠ 0) && enabled.
- Simultaneous push and pop on the same FIFO:
  - Both occur and the count is unchanged.
  - If full, the pop frees the slot, so the push is accepted and no overflow is flagged.
  - If empty, the push is accepted and the pop is ignored (count becomes 1).
- enabled = (uart_mode ≠ 0).
  - While disabled: pushes are ignored without setting overflow, tx_valid = 0, RX pops are still honoured.
  - On the enabled→disabled transition (registered edge detect): both FIFOs are flushed in one cycle (pointers and counts ← 0).
  - Overflow flags are cleared on that same transition.
- Overflow flags are otherwise cleared only by reset.
- port_status = {bitrate[7:0], bitrate[15:8], bitrate[23:16], line_cfg}, registered, 1-cycle latency.
  - Forced to 0 while disabled.
- Reset asserted mid-transfer wins over all same-cycle pushes and pops.

Test Plan:
- Reset with DEPTH_LOG2=4, uart_mode=1 → port_in_available=16, port_out_available=0, tx_valid=0, port_status=0x00 before first update.
- Three rx_valid pulses of 0x41, 0x42, 0x43 → port_out_available=3 one cycle after the last pulse, port_out_data=0x41. Three port_out_strobe pulses yield 0x42, 0x43, then 0x00 with available=0. A fourth strobe changes nothing.
- 17 port_in_strobe pushes with tx_ready=0 → port_in_available=0 after 16, tx_overflow=1 after the 17th. Raise tx_ready → bytes emerge in order, one per cycle, tx_valid drops after the 16th.
- RX FIFO full, then rx_valid and port_out_strobe in the same cycle → count stays 16, no rx_overflow, new byte appears last in order.
- uart_mode 1→0 with 5 bytes in each FIFO → next cycle both counts 0, port_in_available=16, overflow flags 0, port_status=0. Pushes while disabled are ignored.
- bitrate=0x01C200 (115200), line_cfg=0x08 → port_status=0x00C20108.

Source files
------------

// File: rtl/mcu_port_fifo_if.sv
// Signal bundle between mcu_port_fifo and its two neighbours: the MCU port
// channel of the system-control block and the RS232 UART core.
interface mcu_port_fifo_if;
    logic [1:0]  uart_mode;
    logic [23:0] bitrate;
    logic [7:0]  line_cfg;
    logic [31:0] port_status;
    logic [7:0]  port_out_available;
    logic        port_out_strobe;
    logic [7:0]  port_out_data;
    logic [7:0]  port_in_available;
    logic        port_in_strobe;
    logic [7:0]  port_in_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_overflow;
    logic        tx_overflow;

    modport slave (
        input  uart_mode, bitrate, line_cfg,
        input  port_out_strobe, port_in_strobe, port_in_data,
        input  rx_valid, rx_data, tx_ready,
        output port_status, port_out_available, port_out_data, port_in_available,
        output tx_valid, tx_data, rx_overflow, tx_overflow
    );

    modport master (
        output uart_mode, bitrate, line_cfg,
        output port_out_strobe, port_in_strobe, port_in_data,
        output rx_valid, rx_data, tx_ready,
        input  port_status, port_out_available, port_out_data, port_in_available,
        input  tx_valid, tx_data, rx_overflow, tx_overflow
    );
endinterface

// File: rtl/mcu_port_fifo.sv
// Byte FIFOs between the system-control MCU port and the UART: RX (UART->MCU)
// and TX (MCU->UART), first-word fall-through, flushed when the UART is deselected.
module mcu_port_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            reset,
    mcu_port_fifo_if.slave  bus
);
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int RX    = 0;
    localparam int TX    = 1;

    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(1) << DEPTH_LOG2;
    localparam logic [8:0]            DEPTH_9  = 9'(FULL_CNT);
    localparam logic [7:0]            IN_AVAIL_RST = sat8(DEPTH_9);

    logic enabled;
    logic en_q, en_d;
    logic flush;
    logic tx_valid;

    logic [1:0]            push_req, pop_req, ovf_evt;
    logic [1:0][7:0]       wr_data, head;
    logic [1:0][CNT_W-1:0] cnt_now, cnt_next;

    logic        rx_ovf_q, rx_ovf_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic [7:0]  out_avail_q, out_avail_d;
    logic [7:0]  in_avail_q, in_avail_d;
    logic [31:0] status_q, status_d;

    assign enabled  = (bus.uart_mode != 2'd0);
    // Falling edge of the enable is what flushes both directions.
    assign flush    = en_q && !enabled;
    assign tx_valid = (cnt_now[TX] != '0) && enabled;

    always_comb begin
        push_req[RX] = bus.rx_valid && enabled;
        push_req[TX] = bus.port_in_strobe && enabled;
        pop_req[RX]  = bus.port_out_strobe;
        pop_req[TX]  = tx_valid && bus.tx_ready;
        wr_data[RX]  = bus.rx_data;
        wr_data[TX]  = bus.port_in_data;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : fifo_g
            logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
            logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0]      count_q, count_d;
            logic [7:0]            mem [2**DEPTH_LOG2];
            logic                  full, empty, push_ok, pop_ok;

            assign full    = (count_q == FULL_CNT);
            assign empty   = (count_q == '0);
            assign pop_ok  = pop_req[gi] && !empty;
            // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
            assign push_ok = push_req[gi] && (!full || pop_ok);
            assign ovf_evt[gi] = push_req[gi] && full && !pop_ok;

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (flush) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
                    else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push_ok) mem[wr_ptr_q] <= wr_data[gi];
            end

            assign head[gi]     = empty ? 8'h00 : mem[rd_ptr_q];
            assign cnt_now[gi]  = count_q;
            assign cnt_next[gi] = count_d;
        end
    endgenerate

    always_comb begin
        en_d     = enabled;
        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        if (flush) begin
            rx_ovf_d = 1'b0;
            tx_ovf_d = 1'b0;
        end else begin
            if (ovf_evt[RX]) rx_ovf_d = 1'b1;
            if (ovf_evt[TX]) tx_ovf_d = 1'b1;
        end
        out_avail_d = sat8(9'(cnt_next[RX]));
        in_avail_d  = sat8(DEPTH_9 - 9'(cnt_next[TX]));
        // The MCU expects the bitrate byte-swapped ahead of the line config.
        status_d    = enabled ? {bus.bitrate[7:0], bus.bitrate[15:8],
                                 bus.bitrate[23:16], bus.line_cfg} : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q        <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            out_avail_q <= 8'h00;
            in_avail_q  <= IN_AVAIL_RST;
            status_q    <= 32'h0;
        end else begin
            en_q        <= en_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            out_avail_q <= out_avail_d;
            in_avail_q  <= in_avail_d;
            status_q    <= status_d;
        end
    end

    assign bus.port_status        = status_q;
    assign bus.port_out_available = out_avail_q;
    assign bus.port_out_data      = head[RX];
    assign bus.port_in_available  = in_avail_q;
    assign bus.tx_valid           = tx_valid;
    assign bus.tx_data            = head[TX];
    assign bus.rx_overflow        = rx_ovf_q;
    assign bus.tx_overflow        = tx_ovf_q;
endmodule

// File: tb/tb_mcu_port_fifo.sv
// Directed bench for mcu_port_fifo with 16-entry FIFOs: reset state, FIFO
// ordering, full/empty boundaries, disable flush and status word formatting.
module tb_mcu_port_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mcu_port_fifo_if bus();

    mcu_port_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        bus.rx_valid        = 1'b0;
        bus.port_out_strobe = 1'b0;
        bus.port_in_strobe  = 1'b0;
        bus.tx_ready        = 1'b0;
    endtask

    task automatic test_reset();
        bus.uart_mode = 2'd1;
        bus.bitrate = 24'h01C200;
        bus.line_cfg = 8'h08;
        bus.rx_data = 8'h00;
        bus.port_in_data = 8'h00;
        clear_strobes();
        reset = 1'b1;
        tick();
        tick();
        $display("test_reset: reset held for 2 cycles");
        n_checks++; if (bus.port_in_available !== 8'd16) $display("FAIL reset_in_avail: got %0d expected 16", bus.port_in_available); else n_pass++;
        n_checks++; if (bus.port_out_available !== 8'd0) $display("FAIL reset_out_avail: got %0d expected 0", bus.port_out_available); else n_pass++;
        n_checks++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); else n_pass++;
        n_checks++; if (bus.port_status !== 32'h0) $display("FAIL reset_status: got %h expected 00000000", bus.port_status); else n_pass++;
        n_checks++; if (bus.port_out_data !== 8'h00 || bus.tx_data !== 8'h00) $display("FAIL reset_data: got %h/%h expected 00/00", bus.port_out_data, bus.tx_data); else n_pass++;
        n_checks++; if (bus.rx_overflow !== 1'b0 || bus.tx_overflow !== 1'b0) $display("FAIL reset_ovf: got %b/%b expected 0/0", bus.rx_overflow, bus.tx_overflow); else n_pass++;
    endtask

    task automatic test_status_first();
        reset = 1'b0;
        n_checks++; if (bus.port_status !== 32'h0) $display("FAIL status_pre_update: got %h expected 00000000", bus.port_status); else n_pass++;
        tick();
        $display("test_status_first: bitrate=%h line_cfg=%h", bus.bitrate, bus.line_cfg);
        n_checks++; if (bus.port_status !== 32'h00C20108) $display("FAIL status_115200: got %h expected 00c20108", bus.port_status); else n_pass++;
    endtask

    task automatic test_rx_basic();
        logic [7:0] bytes [3];
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = bytes[i];
            tick();
            $display("test_rx_basic: rx byte %h", bytes[i]);
        end
        bus.rx_valid = 1'b0;
        n_checks++; if (bus.port_out_available !== 8'd3) $display("FAIL rx_avail3: got %0d expected 3", bus.port_out_available); else n_pass++;
        n_checks++; if (bus.port_out_data !== 8'h41) $display("FAIL rx_head0: got %h expected 41", bus.port_out_data); else n_pass++;
        bus.port_out_strobe = 1'b1;
        tick();
        n_checks++; if (bus.port_out_data !== 8'h42 || bus.port_out_available !== 8'd2) $display("FAIL rx_pop1: got %h/%0d expected 42/2", bus.port_out_data, bus.port_out_available); else n_pass++;
        tick();
        n_checks++; if (bus.port_out_data !== 8'h43 || bus.port_out_available !== 8'd1) $display("FAIL rx_pop2: got %h/%0d expected 43/1", bus.port_out_data, bus.port_out_available); else n_pass++;
        tick();
        n_checks++; if (bus.port_out_data !== 8'h00 || bus.port_out_available !== 8'd0) $display("FAIL rx_pop3: got %h/%0d expected 00/0", bus.port_out_data, bus.port_out_available); else n_pass++;
        tick();
        bus.port_out_strobe = 1'b0;
        n_checks++; if (bus.port_out_data !== 8'h00 || bus.port_out_available !== 8'd0) $display("FAIL rx_underflow: got %h/%0d expected 00/0", bus.port_out_data, bus.port_out_available); else n_pass++;
        // A byte pushed after the ignored strobe must be the new head.
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h44;
        tick();
        bus.rx_valid = 1'b0;
        n_checks++; if (bus.port_out_data !== 8'h44 || bus.port_out_available !== 8'd1) $display("FAIL rx_after_underflow: got %h/%0d expected 44/1", bus.port_out_data, bus.port_out_available); else n_pass++;
        bus.port_out_strobe = 1'b1;
        tick();
        bus.port_out_strobe = 1'b0;
    endtask

    task automatic test_tx_overflow();
        logic [7:0] b;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 8'h10 + 8'(i);
            bus.port_in_strobe = 1'b1;
            bus.port_in_data = b;
            tick();
            $display("test_tx_overflow: push %h", b);
            n_checks++; if (bus.port_in_available !== 8'(15 - i)) $display("FAIL tx_in_avail_%0d: got %0d expected %0d", i, bus.port_in_available, 15 - i); else n_pass++;
        end
        n_checks++; if (bus.tx_overflow !== 1'b0 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h10) $display("FAIL tx_full_state: got ovf=%b valid=%b data=%h expected 0/1/10", bus.tx_overflow, bus.tx_valid, bus.tx_data); else n_pass++;
        bus.port_in_data = 8'hEE;
        tick();
        bus.port_in_strobe = 1'b0;
        $display("test_tx_overflow: push ee into full fifo");
        n_checks++; if (bus.tx_overflow !== 1'b1 || bus.port_in_available !== 8'd0) $display("FAIL tx_overflow: got ovf=%b avail=%0d expected 1/0", bus.tx_overflow, bus.port_in_available); else n_pass++;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b = 8'h10 + 8'(i);
            n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== b) $display("FAIL tx_drain_%0d: got valid=%b data=%h expected 1/%h", i, bus.tx_valid, bus.tx_data, b); else n_pass++;
            tick();
        end
        bus.tx_ready = 1'b0;
        n_checks++; if (bus.tx_valid !== 1'b0 || bus.port_in_available !== 8'd16) $display("FAIL tx_drained: got valid=%b avail=%0d expected 0/16", bus.tx_valid, bus.port_in_available); else n_pass++;
        n_checks++; if (bus.tx_overflow !== 1'b1) $display("FAIL tx_ovf_sticky: got %b expected 1", bus.tx_overflow); else n_pass++;
    endtask

    task automatic test_rx_full_simul();
        logic [7:0] exp_b;
        for (int i = 0; i < 16; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = 8'h60 + 8'(i);
            tick();
        end
        bus.rx_valid = 1'b0;
        $display("test_rx_full_simul: filled rx fifo with 60..6f");
        n_checks++; if (bus.port_out_available !== 8'd16 || bus.rx_overflow !== 1'b0) $display("FAIL rx_full: got avail=%0d ovf=%b expected 16/0", bus.port_out_available, bus.rx_overflow); else n_pass++;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h7F;
        bus.port_out_strobe = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.port_out_strobe = 1'b0;
        $display("test_rx_full_simul: push 7f with pop while full");
        n_checks++; if (bus.port_out_available !== 8'd16 || bus.rx_overflow !== 1'b0 || bus.port_out_data !== 8'h61) $display("FAIL rx_full_simul: got avail=%0d ovf=%b head=%h expected 16/0/61", bus.port_out_available, bus.rx_overflow, bus.port_out_data); else n_pass++;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h80;
        tick();
        bus.rx_valid = 1'b0;
        $display("test_rx_full_simul: push 80 while full");
        n_checks++; if (bus.rx_overflow !== 1'b1 || bus.port_out_available !== 8'd16) $display("FAIL rx_overflow: got ovf=%b avail=%0d expected 1/16", bus.rx_overflow, bus.port_out_available); else n_pass++;
        bus.port_out_strobe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'h61 + 8'(i) : 8'h7F;
            n_checks++; if (bus.port_out_data !== exp_b) $display("FAIL rx_order_%0d: got %h expected %h", i, bus.port_out_data, exp_b); else n_pass++;
            tick();
        end
        bus.port_out_strobe = 1'b0;
        n_checks++; if (bus.port_out_available !== 8'd0 || bus.port_out_data !== 8'h00) $display("FAIL rx_drained: got avail=%0d head=%h expected 0/00", bus.port_out_available, bus.port_out_data); else n_pass++;
    endtask

    task automatic test_simul_empty();
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h99;
        bus.port_out_strobe = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.port_out_strobe = 1'b0;
        $display("test_simul_empty: push 99 with pop while empty");
        n_checks++; if (bus.port_out_available !== 8'd1 || bus.port_out_data !== 8'h99) $display("FAIL simul_empty: got avail=%0d head=%h expected 1/99", bus.port_out_available, bus.port_out_data); else n_pass++;
        bus.port_out_strobe = 1'b1;
        tick();
        bus.port_out_strobe = 1'b0;
        n_checks++; if (bus.port_out_available !== 8'd0) $display("FAIL simul_empty_pop: got %0d expected 0", bus.port_out_available); else n_pass++;
    endtask

    task automatic test_disable();
        for (int i = 0; i < 5; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = 8'h20 + 8'(i);
            bus.port_in_strobe = 1'b1;
            bus.port_in_data = 8'h30 + 8'(i);
            tick();
        end
        clear_strobes();
        $display("test_disable: 5 bytes in each fifo");
        n_checks++; if (bus.port_out_available !== 8'd5 || bus.port_in_available !== 8'd11) $display("FAIL dis_prefill: got out=%0d in=%0d expected 5/11", bus.port_out_available, bus.port_in_available); else n_pass++;
        n_checks++; if (bus.rx_overflow !== 1'b1 || bus.tx_overflow !== 1'b1) $display("FAIL dis_ovf_before: got %b/%b expected 1/1", bus.rx_overflow, bus.tx_overflow); else n_pass++;
        bus.uart_mode = 2'd0;
        tick();
        $display("test_disable: uart_mode 1->0");
        n_checks++; if (bus.port_out_available !== 8'd0 || bus.port_in_available !== 8'd16) $display("FAIL dis_flush: got out=%0d in=%0d expected 0/16", bus.port_out_available, bus.port_in_available); else n_pass++;
        n_checks++; if (bus.rx_overflow !== 1'b0 || bus.tx_overflow !== 1'b0) $display("FAIL dis_ovf_clear: got %b/%b expected 0/0", bus.rx_overflow, bus.tx_overflow); else n_pass++;
        n_checks++; if (bus.port_status !== 32'h0 || bus.tx_valid !== 1'b0 || bus.port_out_data !== 8'h00) $display("FAIL dis_outputs: got status=%h valid=%b head=%h expected 0/0/00", bus.port_status, bus.tx_valid, bus.port_out_data); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = 8'hA0;
            bus.port_in_strobe = 1'b1;
            bus.port_in_data = 8'hB0;
            tick();
        end
        clear_strobes();
        $display("test_disable: 2 pushes while disabled");
        n_checks++; if (bus.port_out_available !== 8'd0 || bus.port_in_available !== 8'd16 || bus.tx_valid !== 1'b0) $display("FAIL dis_push_ignored: got out=%0d in=%0d valid=%b expected 0/16/0", bus.port_out_available, bus.port_in_available, bus.tx_valid); else n_pass++;
        bus.uart_mode = 2'd2;
        tick();
        n_checks++; if (bus.port_out_available !== 8'd0 || bus.tx_valid !== 1'b0) $display("FAIL reenable_empty: got out=%0d valid=%b expected 0/0", bus.port_out_available, bus.tx_valid); else n_pass++;
    endtask

    task automatic test_status_latency();
        n_checks++; if (bus.port_status !== 32'h00C20108) $display("FAIL status_reenabled: got %h expected 00c20108", bus.port_status); else n_pass++;
        bus.bitrate = 24'h123456;
        bus.line_cfg = 8'hA5;
        #1;
        n_checks++; if (bus.port_status !== 32'h00C20108) $display("FAIL status_latency: got %h expected 00c20108", bus.port_status); else n_pass++;
        tick();
        $display("test_status_latency: bitrate=%h line_cfg=%h", bus.bitrate, bus.line_cfg);
        n_checks++; if (bus.port_status !== 32'h563412A5) $display("FAIL status_swap: got %h expected 563412a5", bus.port_status); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = 8'hC0 + 8'(i);
            bus.port_in_strobe = 1'b1;
            bus.port_in_data = 8'hD0 + 8'(i);
            tick();
        end
        bus.port_out_strobe = 1'b1;
        bus.tx_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_strobes();
        $display("test_reset_mid: reset with push and pop active");
        n_checks++; if (bus.port_out_available !== 8'd0 || bus.port_in_available !== 8'd16) $display("FAIL reset_mid_avail: got out=%0d in=%0d expected 0/16", bus.port_out_available, bus.port_in_available); else n_pass++;
        n_checks++; if (bus.tx_valid !== 1'b0 || bus.port_out_data !== 8'h00 || bus.port_status !== 32'h0) $display("FAIL reset_mid_outputs: got valid=%b head=%h status=%h expected 0/00/0", bus.tx_valid, bus.port_out_data, bus.port_status); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_status_first();
        test_rx_basic();
        test_tx_overflow();
        test_rx_full_simul();
        test_simul_empty();
        test_disable();
        test_status_latency();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
